// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the 4-way mux sequencers: state encoding,
// select width and a small one-hot helper.
package mux_rr_arbiter_pkg;

    localparam int SEL_W = 2;
    localparam int NREQ  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters. The search starts
// one position after last_owner and wraps, so the previous owner has the
// lowest priority.
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_owner,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] cand [NREQ];
    logic [NREQ-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            // Candidate gi is the (gi+1)-th index after the last owner, mod 4.
            assign cand[gi] = last_owner + SEL_W'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest-numbered hit (closest to last_owner+1) wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-to-1 operand mux. Grants one
// requester at a time, drives the mux select, and registers the mux output
// into a valid/ready output stage. A grant is bounded to MAX_BURST words
// only while someone else is waiting.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_out,
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] last_reg;
    logic [3:0]       gnt_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    logic [SEL_W-1:0] winner;
    logic             any_req;

    rr_pick4 u_pick (
        .req        (req),
        .last_owner (last_reg),
        .winner     (winner),
        .any_req    (any_req)
    );

    // While granted, the owner is whatever sel points at (sel is frozen
    // for the whole grant).
    logic [3:0] owner_oh;
    logic       in_grant;
    logic       owner_req;
    logic       xfer;
    logic       burst_end;
    logic       others_waiting;
    logic       release_now;

    assign owner_oh       = onehot4(sel_reg);
    assign in_grant       = (state_reg == ST_GRANT);
    assign owner_req      = req[sel_reg];
    assign xfer           = in_grant & owner_req & (~valid_reg | out_ready);
    assign burst_end      = (cnt_reg == CNT_W'(MAX_BURST - 1));
    assign others_waiting = |(req & ~owner_oh);
    assign release_now    = in_grant & (~owner_req | (xfer & burst_end & others_waiting));

    assign sel       = sel_reg;
    assign gnt       = gnt_reg;
    assign ack       = xfer ? owner_oh : 4'b0000;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    // Arbitration FSM: pick a winner in IDLE, hold the grant until the owner
    // drops req or exhausts its burst while others are waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            last_reg  <= SEL_W'(3);
            gnt_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg <= ST_GRANT;
                        sel_reg   <= winner;
                        gnt_reg   <= onehot4(winner);
                        cnt_reg   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state_reg <= ST_IDLE;
                        last_reg  <= sel_reg;
                        gnt_reg   <= '0;
                    end else if (xfer) begin
                        // Uncontended owner keeps the grant; the count just wraps.
                        cnt_reg <= burst_end ? '0 : cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

    // Output register: load on transfer, clear valid when consumed with no
    // replacement word. Load-and-consume in one cycle keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (xfer) begin
            data_reg  <= mux_out;
            valid_reg <= 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_BURST 8 and 2) share the
// request/ready stimulus; each has its own emulated MUX_4to1. A per-cycle
// behavioural model checks every output, and directed scenarios add
// hand-computed literal checks.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        out_ready = 1'b0;
    logic        mux_mode = 1'b0;
    logic [15:0] fixed_val = 16'hA5A5;
    logic [7:0]  cyc = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 8'd1;

    logic [1:0]  sel_a, sel_b;
    logic [3:0]  gnt_a, gnt_b, ack_a, ack_b;
    logic [15:0] data_a, data_b, mux_a, mux_b;
    logic        valid_a, valid_b;

    // Emulated external mux: fixed word, or a word tagged with select and cycle.
    assign mux_a = mux_mode ? {sel_a, 6'd0, cyc} : fixed_val;
    assign mux_b = mux_mode ? {sel_b, 6'd0, cyc} : fixed_val;

    mux_rr_arbiter #(.WIDTH(16), .MAX_BURST(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_a), .sel(sel_a),
        .gnt(gnt_a), .ack(ack_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(out_ready)
    );

    mux_rr_arbiter #(.WIDTH(16), .MAX_BURST(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_b), .sel(sel_b),
        .gnt(gnt_b), .ack(ack_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(out_ready)
    );

    logic [1:0]  d_sel  [2];
    logic [3:0]  d_gnt  [2];
    logic [3:0]  d_ack  [2];
    logic [15:0] d_data [2];
    logic        d_val  [2];
    assign d_sel[0] = sel_a;   assign d_sel[1] = sel_b;
    assign d_gnt[0] = gnt_a;   assign d_gnt[1] = gnt_b;
    assign d_ack[0] = ack_a;   assign d_ack[1] = ack_b;
    assign d_data[0] = data_a; assign d_data[1] = data_b;
    assign d_val[0] = valid_a; assign d_val[1] = valid_b;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Model state per instance.
    int          mb [2] = '{8, 2};
    bit          m_busy [2];
    int          m_own [2];
    int          m_last [2];
    int          m_cnt [2];
    int          m_sel [2];
    bit          m_ov [2];
    logic [15:0] m_od [2];

    // Observation counters, only written by the monitor.
    int          ack_n [2];
    int          idle_n [2];
    int          own_log [$];
    logic [3:0]  prev_gnt [2];

    logic [3:0]  eg, ea;
    bit          xf, found;
    logic [15:0] w;
    int          c;

    // Compare process: inputs are stable between posedge+1 and the next
    // posedge, so at the falling edge the model predicts the current outputs
    // and then advances to what the next rising edge must produce.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0; m_own[k] = 0; m_last[k] = 3; m_cnt[k] = 0;
                m_sel[k] = 0; m_ov[k] = 1'b0; m_od[k] = 16'h0000;
            end
            xf = m_busy[k] && req[m_own[k]] && (!m_ov[k] || out_ready);
            eg = m_busy[k] ? 4'(1 << m_own[k]) : 4'b0000;
            ea = xf ? eg : 4'b0000;
            chk($sformatf("dut%0d gnt", k), 32'(d_gnt[k]), 32'(eg));
            chk($sformatf("dut%0d ack", k), 32'(d_ack[k]), 32'(ea));
            chk($sformatf("dut%0d sel", k), 32'(d_sel[k]), 32'(m_sel[k]));
            chk($sformatf("dut%0d out_valid", k), 32'(d_val[k]), 32'(m_ov[k]));
            chk($sformatf("dut%0d out_data", k), 32'(d_data[k]), 32'(m_od[k]));

            if (d_ack[k] != 4'b0000) ack_n[k]++;
            if (d_gnt[k] == 4'b0000) idle_n[k]++;
            if (k == 1 && d_gnt[k] != 4'b0000 && prev_gnt[k] == 4'b0000) begin
                for (int j = 0; j < 4; j++) if (d_gnt[k][j]) own_log.push_back(j);
            end
            prev_gnt[k] = d_gnt[k];
            if (k == 0 && d_ack[k] != 4'b0000)
                $display("t=%0t dut0 ack=%b sel=%0d word=%h", $time, d_ack[k], d_sel[k], mux_a);

            if (!rst) begin
                w = mux_mode ? {2'(m_sel[k]), 6'd0, cyc} : fixed_val;
                if (xf) begin
                    m_od[k] = w; m_ov[k] = 1'b1;
                end else if (m_ov[k] && out_ready) begin
                    m_ov[k] = 1'b0;
                end
                if (m_busy[k]) begin
                    if (!req[m_own[k]]) begin
                        m_busy[k] = 1'b0; m_last[k] = m_own[k];
                    end else if (xf) begin
                        if (m_cnt[k] + 1 == mb[k]) begin
                            if ((req & ~eg) != 4'b0000) begin
                                m_busy[k] = 1'b0; m_last[k] = m_own[k];
                            end else begin
                                m_cnt[k] = 0;
                            end
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end
                end else begin
                    found = 1'b0;
                    for (int i = 1; i <= 4; i++) begin
                        c = (m_last[k] + i) % 4;
                        if (!found && req[c]) begin
                            found = 1'b1; m_busy[k] = 1'b1; m_own[k] = c;
                            m_sel[k] = c; m_cnt[k] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int base0, base1, ib0, lb;
    logic [7:0] c0;
    int exp_own [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state.
        rst = 1'b1;
        step(2);
        chk("reset gnt", 32'(gnt_a), 32'h0);
        chk("reset sel", 32'(sel_a), 32'h0);
        chk("reset out_valid", 32'(valid_a), 32'h0);
        chk("reset out_data", 32'(data_a), 32'h0);
        rst = 1'b0;

        // Single requester 2 with a fixed mux word.
        req = 4'b0100; out_ready = 1'b1; mux_mode = 1'b0;
        step(1);
        chk("single gnt", 32'(gnt_a), 32'h4);
        chk("single sel", 32'(sel_a), 32'h2);
        chk("single ack", 32'(ack_a), 32'h4);
        step(1);
        chk("single out_data", 32'(data_a), 32'hA5A5);
        chk("single out_valid", 32'(valid_a), 32'h1);
        req = 4'b0000;
        step(3);

        // Round robin with all four requesting, MAX_BURST=2 instance.
        pulse_reset();
        mux_mode = 1'b1; req = 4'b1111;
        base1 = ack_n[1]; lb = own_log.size();
        step(15);
        chk("rr ack count", 32'(ack_n[1] - base1), 32'd10);
        chk("rr grant count", 32'(own_log.size() - lb), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (lb + i < own_log.size())
                chk($sformatf("rr owner %0d", i), 32'(own_log[lb + i]), 32'(exp_own[i]));
        end
        req = 4'b0000;
        step(3);

        // Uncontended burst: grant never released, count wraps.
        pulse_reset();
        req = 4'b0010;
        base0 = ack_n[0]; base1 = ack_n[1]; ib0 = idle_n[0];
        step(20);
        chk("solo ack count mb8", 32'(ack_n[0] - base0), 32'd19);
        chk("solo ack count mb2", 32'(ack_n[1] - base1), 32'd19);
        chk("solo idle cycles", 32'(idle_n[0] - ib0), 32'd1);
        req = 4'b0000;
        step(3);

        // Backpressure on owner 3.
        pulse_reset();
        out_ready = 1'b0; req = 4'b1000; c0 = cyc;
        base0 = ack_n[0];
        step(5);
        chk("bp ack count stalled", 32'(ack_n[0] - base0), 32'd1);
        chk("bp out_valid held", 32'(valid_a), 32'h1);
        chk("bp out_data held", 32'(data_a), 32'({2'b11, 6'd0, 8'(c0 + 8'd1)}));
        out_ready = 1'b1;
        base0 = ack_n[0];
        step(4);
        chk("bp ack count resumed", 32'(ack_n[0] - base0), 32'd4);
        req = 4'b0000;
        step(3);
        chk("bp drained", 32'(valid_a), 32'h0);

        // Early release by owner 0 while requester 2 waits.
        pulse_reset();
        req = 4'b0101;
        base0 = ack_n[0];
        step(4);
        chk("early ack count", 32'(ack_n[0] - base0), 32'd3);
        req = 4'b0100;
        #1;
        chk("early release gnt", 32'(gnt_a), 32'h1);
        chk("early release ack", 32'(ack_a), 32'h0);
        step(1);
        chk("early idle gnt", 32'(gnt_a), 32'h0);
        step(1);
        chk("early new gnt", 32'(gnt_a), 32'h4);
        chk("early new sel", 32'(sel_a), 32'h2);
        req = 4'b0000;
        step(3);

        // Asynchronous reset mid-burst (last owner is 2, so requester 1 wins).
        req = 4'b0110;
        step(3);
        chk("async pre gnt", 32'(gnt_a), 32'h2);
        chk("async pre sel", 32'(sel_a), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("async gnt", 32'(gnt_a), 32'h0);
        chk("async out_valid", 32'(valid_a), 32'h0);
        chk("async sel", 32'(sel_a), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 4'b1001;
        step(1);
        chk("post reset gnt", 32'(gnt_a), 32'h1);
        chk("post reset sel", 32'(sel_a), 32'h0);
        req = 4'b0000;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
